// File: rtl/branch_ctrl_pkg.sv
// Shared opcode, condition-code and branch-FSM encodings for the branch controller.
// Every file that decodes instructions or names FSM states imports these constants.
package branch_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_B    = 4'hC;

    // Condition field of a B instruction, evaluated by the flag unit
    localparam logic [2:0] CC_AL = 3'd0;
    localparam logic [2:0] CC_EQ = 3'd1;
    localparam logic [2:0] CC_NE = 3'd2;
    localparam logic [2:0] CC_LT = 3'd3;
    localparam logic [2:0] CC_GE = 3'd4;
    localparam logic [2:0] CC_CS = 3'd5;
    localparam logic [2:0] CC_CC = 3'd6;
    localparam logic [2:0] CC_MI = 3'd7;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_EVAL     = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    function automatic logic is_flag_setter(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op == OP_XOR) || (op == OP_INC);
    endfunction

    // Target is relative to the instruction after the branch; the add wraps mod 2^16
    function automatic logic [15:0] branch_target(input logic [15:0] pc, input logic [7:0] off);
        return pc + 16'd1 + {{8{off[7]}}, off};
    endfunction

endpackage

// File: rtl/br_stats.sv
// Saturating pair of branch statistics counters: resolved branches and taken branches.
module br_stats #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         resolve,
    input  logic         taken,
    output logic [W-1:0] total,
    output logic [W-1:0] taken_count
);

    // Both counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total       <= '0;
            taken_count <= '0;
        end else begin
            if (resolve && (total != '1))
                total <= total + 1'b1;
            if (resolve && taken && (taken_count != '1))
                taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: detects B in decode, waits out a flag hazard from EX,
// resolves the condition, redirects the PC and squashes the wrong-path fetch.
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [15:0] id_instr,
    input  logic [15:0] id_pc,
    input  logic        ex_valid,
    input  logic [15:0] ex_instr,
    input  logic        cond_true,
    output logic        stall,
    output logic        flush,
    output logic        pc_sel,
    output logic [15:0] br_target,
    output logic [15:0] br_total,
    output logic [15:0] br_taken
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       br_det;
    logic       ex_setter;
    logic       capture;
    logic       resolve;
    logic       unused_bits;

    assign br_det      = id_valid && (id_instr[15:12] == OP_B);
    assign ex_setter   = ex_valid && is_flag_setter(ex_instr[15:12]);
    assign unused_bits = ^{id_instr[11:8], ex_instr[11:0]};

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        flush     = 1'b0;
        pc_sel    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (br_det) begin
                    stall     = 1'b1;
                    state_nxt = ex_setter ? ST_WAIT : ST_EVAL;
                end
            end
            ST_WAIT: begin
                // flags from the EX setter land at the end of this cycle
                stall     = 1'b1;
                state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                pc_sel    = cond_true;
                flush     = cond_true;
                state_nxt = cond_true ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign capture = (state == ST_IDLE) && br_det;
    assign resolve = (state == ST_EVAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            br_target <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (capture)
                br_target <= branch_target(id_pc, id_instr[7:0]);
        end
    end

    br_stats #(.W(16)) u_stats (
        .clk         (clk),
        .rst         (rst),
        .resolve     (resolve),
        .taken       (cond_true),
        .total       (br_total),
        .taken_count (br_taken)
    );

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares against the DUT.
module tb_branch_ctrl;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        pc_sel;
        logic [15:0] tgt;
        logic [15:0] tot;
        logic [15:0] tkn;
    } exp_t;

    typedef struct packed {
        logic [3:0] tot;
        logic [3:0] tkn;
    } sat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [15:0] id_instr = '0;
    logic [15:0] id_pc = '0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_instr = '0;
    logic        cond_true = 1'b0;
    logic        stall, flush, pc_sel;
    logic [15:0] br_target, br_total, br_taken;

    logic        s_rst = 1'b1;
    logic        s_res = 1'b0;
    logic        s_tkn = 1'b0;
    logic [3:0]  s_total, s_taken;

    exp_t q[$];
    sat_t sq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   c_idx  = 0;
    int   s_idx  = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .ex_valid  (ex_valid),
        .ex_instr  (ex_instr),
        .cond_true (cond_true),
        .stall     (stall),
        .flush     (flush),
        .pc_sel    (pc_sel),
        .br_target (br_target),
        .br_total  (br_total),
        .br_taken  (br_taken)
    );

    // Narrow instance so saturation is reachable in a few cycles
    br_stats #(.W(4)) u_sat (
        .clk         (clk),
        .rst         (s_rst),
        .resolve     (s_res),
        .taken       (s_tkn),
        .total       (s_total),
        .taken_count (s_taken)
    );

    function automatic exp_t mk(input logic st, fl, ps, input logic [15:0] tgt, tot, tkn);
        exp_t e;
        e.stall = st; e.flush = fl; e.pc_sel = ps;
        e.tgt = tgt; e.tot = tot; e.tkn = tkn;
        return e;
    endfunction

    task automatic step(input logic r, v, input logic [15:0] ins, pc,
                        input logic exv, input logic [15:0] exi, input logic ct, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_instr = ins; id_pc = pc;
        ex_valid = exv; ex_instr = exi; cond_true = ct;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        sat_t se, sg;
        if (q.size() > 0) begin
            e = q.pop_front();
            g = {stall, flush, pc_sel, br_target, br_total, br_taken};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ctrl[%0d]: got stall=%b flush=%b pc_sel=%b tgt=%h total=%h taken=%h, want stall=%b flush=%b pc_sel=%b tgt=%h total=%h taken=%h",
                         c_idx, g.stall, g.flush, g.pc_sel, g.tgt, g.tot, g.tkn,
                         e.stall, e.flush, e.pc_sel, e.tgt, e.tot, e.tkn);
            end
            c_idx++;
        end
        if (sq.size() > 0) begin
            se = sq.pop_front();
            sg = {s_total, s_taken};
            n_chk++;
            if (sg !== se) begin
                n_fail++;
                $display("FAIL sat[%0d]: got total=%h taken=%h, want total=%h taken=%h",
                         s_idx, sg.tot, sg.tkn, se.tot, se.tkn);
            end
            s_idx++;
        end
    end

    initial begin
        int m_tot, m_tkn, guard;
        logic r_i, t_i;
        // reset and idle
        step(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h0000, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h0000, 0, 0));
        // not taken, no hazard
        step(0, 1, 16'hC0FE, 16'h0010, 0, 16'h0000, 0, mk(1, 0, 0, 16'h0000, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h000F, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h000F, 1, 0));
        // taken; branch present during REDIRECT must be ignored
        step(0, 1, 16'hC0FE, 16'h0010, 0, 16'h0000, 0, mk(1, 0, 0, 16'h000F, 1, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, mk(0, 1, 1, 16'h000F, 1, 0));
        step(0, 1, 16'hC0FE, 16'h0010, 1, 16'h1000, 1, mk(0, 1, 0, 16'h000F, 2, 1));
        // hazard with ADD in EX, target wraps to 0005, not taken
        step(0, 1, 16'hC005, 16'hFFFF, 1, 16'h1000, 0, mk(1, 0, 0, 16'h000F, 2, 1));
        step(0, 1, 16'hC005, 16'hFFFF, 0, 16'h0000, 1, mk(1, 0, 0, 16'h0005, 2, 1));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h0005, 2, 1));
        // invalid B and valid non-B leave IDLE alone
        step(0, 0, 16'hC080, 16'h0000, 1, 16'h1000, 1, mk(0, 0, 0, 16'h0005, 3, 1));
        step(0, 1, 16'h1080, 16'h0000, 1, 16'h1000, 1, mk(0, 0, 0, 16'h0005, 3, 1));
        // hazard with INC, negative offset wraps to FF81, taken
        step(0, 1, 16'hC080, 16'h0000, 1, 16'h5000, 0, mk(1, 0, 0, 16'h0005, 3, 1));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(1, 0, 0, 16'hFF81, 3, 1));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, mk(0, 1, 1, 16'hFF81, 3, 1));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 1, 0, 16'hFF81, 4, 2));
        // ADD opcode in EX but ex_valid low: no hazard
        step(0, 1, 16'hC0FE, 16'h0010, 0, 16'h1000, 0, mk(1, 0, 0, 16'hFF81, 4, 2));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h000F, 4, 2));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h000F, 5, 2));
        // reset raised mid-cycle during WAIT clears outputs before any edge
        step(0, 1, 16'hC0FE, 16'h0010, 1, 16'h2000, 0, mk(1, 0, 0, 16'h000F, 5, 2));
        step(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h0000, 0, 0));
        step(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h0000, 0, 0));
        // operation resumes right after release
        step(0, 1, 16'hC0FE, 16'h0010, 0, 16'h0000, 0, mk(1, 0, 0, 16'h0000, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, mk(0, 1, 1, 16'h000F, 0, 0));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 1, 0, 16'h000F, 1, 1));
        step(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, mk(0, 0, 0, 16'h000F, 1, 1));

        // saturation on the narrow counter pair
        @(posedge clk); #1; s_rst = 1'b0;
        m_tot = 0; m_tkn = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            r_i = (i != 2) && (i < 23);
            t_i = (i % 5) != 4;
            s_res = r_i; s_tkn = t_i;
            sq.push_back({4'(m_tot), 4'(m_tkn)});
            if (r_i && m_tot < 15) m_tot++;
            if (r_i && t_i && m_tkn < 15) m_tkn++;
        end

        guard = 0;
        while ((q.size() > 0 || sq.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (q.size() > 0 || sq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d ctrl and %0d sat entries left, want 0", q.size(), sq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 id_valid  input  1  decode-stage instruction valid.
REQ-004 id_instr  input  16  decode-stage instruction; opcode [15:12], cond [10:8], offset [7:0].
REQ-005 id_pc  input  16  address of id_instr.
REQ-006 ex_valid  input  1  execute-stage instruction valid.
REQ-007 ex_instr  input  16  execute-stage instruction; opcode [15:12].
REQ-008 cond_true  input  1  condition result from the flag unit for the branch in decode.
REQ-009 stall  output  1  hold PC and IF/ID, insert bubble into EX.
REQ-010 flush  output  1  squash IF/ID contents.
REQ-011 pc_sel  output  1  1 = load br_target into PC.
REQ-012 br_target  output  16  latched branch target.
REQ-013 br_total  output  16  count of resolved branches.
REQ-014 br_taken  output  16  count of taken branches.

Function
REQ-015 Branch detect: id_valid=1 and id_instr[15:12]==B; ex flag-setter: ex_valid=1 and ex_instr[15:12] in {ADD, SUB, NAND, XOR, INC}.
REQ-016 States: IDLE, WAIT, EVAL, REDIRECT; reset state IDLE.
REQ-017 IDLE: branch detected -> stall=1, latch br_target; next WAIT if ex flag-setter, else EVAL; no branch -> stay, all controls 0.
REQ-018 WAIT: stall=1 for exactly one cycle (flags written at that edge); next EVAL.
REQ-019 EVAL: sample cond_true; stall=0; increment br_total.
REQ-020 EVAL with cond_true=1: pc_sel=1, flush=1 in the same cycle; increment br_taken; next REDIRECT.
REQ-021 EVAL with cond_true=0: pc_sel=0, flush=0; next IDLE.
REQ-022 REDIRECT: flush=1, stall=0, pc_sel=0 for one cycle to squash the wrong-path fetch; next IDLE, and a branch in decode is not detected in this cycle.
REQ-023 br_target = id_pc + 1 + sign-extend(offset[7:0]), 16-bit, wrapping modulo 2^16, captured on IDLE exit and held until the next capture.
REQ-024 Counters saturate at 16'hFFFF and do not wrap.
REQ-025 id_valid=0 or non-B opcode in IDLE -> no state change, whatever ex_instr is.
REQ-026 Per-branch latency: not taken = 1 stall cycle (2 with hazard); taken = 1 stall + 2 flush cycles (2 stalls with hazard).
REQ-027 Outputs stall, flush, pc_sel are combinational from state and inputs; no output glitches on clk edges are required beyond standard synchronous design.

Reset
REQ-028 rst=1 -> state IDLE, br_target=0, br_total=0, br_taken=0, stall=flush=pc_sel=0, immediately and independent of clk.
REQ-029 Reset in any state aborts the in-flight branch, with no counter increment; normal operation resumes on the first rising edge after rst deasserts.

Structure
REQ-030 Opcode codes (ADD, SUB, NAND, XOR, INC, B), condition codes and the state encoding belong in the shared opcode/condition-code headers; no local redefinition.
REQ-031 Saturating counter pair in sub-module br_stats (inputs: clk, rst, resolve, taken); the FSM and target adder stay in branch_ctrl.

Verification
REQ-032 Not taken: id_pc=16'h0010, B, offset 8'hFE, no EX setter, cond_true=0 at EVAL -> stall 1 cycle, pc_sel never 1, br_total=1, br_taken=0.
REQ-033 Taken: same, cond_true=1 -> br_target=16'h000F, pc_sel=1 and flush=1 in EVAL, flush=1 next cycle, br_taken=1.
REQ-034 Hazard: ADD in EX with B in decode -> state sequence IDLE, WAIT, EVAL; stall=1 for 2 cycles.
REQ-035 Wrap: id_pc=16'hFFFF, offset 8'h05 -> br_target=16'h0005; id_pc=16'h0000, offset 8'h80 -> br_target=16'hFF81.
REQ-036 Reset mid-op: assert rst during WAIT -> outputs 0 without a clock edge, counters 0, IDLE after release.
REQ-037 Saturation: 65 537 taken branches -> br_total=br_taken=16'hFFFF.
